// File: rtl/writeback_arbiter.sv
// ============================================================================
// writeback_arbiter : three-source register-file write-back arbiter with one
//                     holding entry per source, per-register write ordering
//                     and round-robin grant.
// Revision : 1.0
// ============================================================================
`default_nettype none

module writeback_arbiter #(
   parameter int DATA_W = 32,
   parameter int N_REQ  = 3
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [N_REQ-1:0]        req_valid_i,
   input  logic [5*N_REQ-1:0]      req_rd_i,
   input  logic [DATA_W*N_REQ-1:0] req_data_i,
   output logic [N_REQ-1:0]        req_ready_o,
   input  logic                    stall_wb_i,
   output logic                    reg_write_wb_o,
   output logic [4:0]              reg_rd_wb_o,
   output logic [DATA_W-1:0]       reg_rd_data_wb_o,
   output logic                    busy_o
);

   logic [N_REQ-1:0]  valid_q;
   logic [N_REQ-1:0]  valid_d;
   logic [4:0]        rd_q    [N_REQ];
   logic [DATA_W-1:0] data_q  [N_REQ];
   logic [N_REQ-1:0]  older_q [N_REQ];
   logic [N_REQ-1:0]  older_d [N_REQ];
   logic [1:0]        last_grant_q;

   logic [4:0]        req_rd   [N_REQ];
   logic [DATA_W-1:0] req_data [N_REQ];
   logic [N_REQ-1:0]  eligible;
   logic [N_REQ-1:0]  grant;
   logic [N_REQ-1:0]  accept;
   logic [N_REQ-1:0]  store;
   logic [1:0]        grant_idx;
   logic              grant_any;

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign req_rd[k]   = req_rd_i[5*k +: 5];
      assign req_data[k] = req_data_i[DATA_W*k +: DATA_W];
   end

   // An entry waits while any older pending entry targets the same register.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         eligible[i] = valid_q[i];
         for (int j = 0; j < N_REQ; j++) begin
            if (j != i && valid_q[j] && older_q[j][i] && (rd_q[j] == rd_q[i]))
               eligible[i] = 1'b0;
         end
      end
   end

   always_comb begin
      logic [1:0] idx;
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = last_grant_q;
      idx       = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         idx = 2'((int'(last_grant_q) + off) % N_REQ);
         if (!grant_any && !stall_wb_i && eligible[idx]) begin
            grant_any = 1'b1;
            grant_idx = idx;
         end
      end
      if (grant_any)
         grant[grant_idx] = 1'b1;
   end

   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         req_ready_o[k] = !valid_q[k] || grant[k];
         accept[k]      = req_valid_i[k] && req_ready_o[k];
         store[k]       = accept[k] && (req_rd[k] != 5'd0);
         valid_d[k]     = (valid_q[k] && !grant[k]) || store[k];
      end
   end

   // Newly stored entries are younger than all survivors; among themselves
   // the lower index is older.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         older_d[i] = '0;
         for (int j = 0; j < N_REQ; j++) begin
            if (i == j)
               older_d[i][j] = 1'b0;
            else if (store[i] && store[j])
               older_d[i][j] = (i < j);
            else if (store[i])
               older_d[i][j] = 1'b0;
            else if (store[j])
               older_d[i][j] = 1'b1;
            else
               older_d[i][j] = older_q[i][j];
         end
      end
   end

   assign busy_o = |valid_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q          <= '0;
         last_grant_q     <= 2'd2;
         reg_write_wb_o   <= 1'b0;
         reg_rd_wb_o      <= 5'd0;
         reg_rd_data_wb_o <= '0;
         for (int k = 0; k < N_REQ; k++) begin
            rd_q[k]    <= 5'd0;
            data_q[k]  <= '0;
            older_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < N_REQ; k++) begin
            older_q[k] <= older_d[k];
            if (store[k]) begin
               rd_q[k]   <= req_rd[k];
               data_q[k] <= req_data[k];
            end
         end
         if (grant_any) begin
            last_grant_q     <= grant_idx;
            reg_write_wb_o   <= 1'b1;
            reg_rd_wb_o      <= rd_q[grant_idx];
            reg_rd_data_wb_o <= data_q[grant_idx];
         end else begin
            reg_write_wb_o   <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire
